// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared types for the AXI interconnect write-response path
package axi_ic_pkg;

  // Owner of a write transaction: which slave interface issued the address
  typedef enum logic {SEL_S00 = 1'b0, SEL_S01 = 1'b1} slave_sel_e;

  // Write-response routing controller states
  typedef enum logic {BR_EMPTY = 1'b0, BR_ACTIVE = 1'b1} bresp_st_e;

endpackage

// File: rtl/owner_fifo.sv
// rtl/owner_fifo.sv - in-order 1-bit ordering FIFO holding the owner of each outstanding write
module owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Occupancy is held separately from the pointers so full and empty stay distinct
  // when the pointers coincide.
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Entry storage, pointer advance and occupancy tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 1'b0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_bresp_route_ctrl.sv
// rtl/axi_bresp_route_ctrl.sv - steers write responses back to the owning slave interface in order
module axi_bresp_route_ctrl
  import axi_ic_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          aw_accept,
  input  logic          aw_owner,
  output logic          aw_stall,
  input  logic          M_AXI_bvalid,
  output logic          M_AXI_bready,
  output logic          Selected_Slave,
  input  logic          Sele_S_AXI_bready,
  output logic          S00_AXI_bvalid,
  output logic          S01_AXI_bvalid,
  output logic [CW-1:0] out_cnt_s00,
  output logic [CW-1:0] out_cnt_s01,
  output logic          err_unexp_b
);

  bresp_st_e     r_st;
  logic [CW-1:0] r_cnt_s00;
  logic [CW-1:0] r_cnt_s01;
  logic          r_err;
  logic          w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  slave_sel_e    w_head;
  logic          w_active;
  logic          w_push;
  logic          w_pop;

  owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_push  (w_push),
    .i_din   (aw_owner),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Stall comes from the registered occupancy only, so a pop in a full cycle
  // cannot let a push through in the same cycle.
  assign aw_stall = w_fifo_full;
  assign w_active = (r_st == BR_ACTIVE);
  assign w_head   = slave_sel_e'(w_fifo_head);
  assign w_push   = aw_accept & ~aw_stall;

  // A response is only ever consumed when its owner is ready; nothing is
  // accepted while no write is outstanding.
  assign M_AXI_bready   = Sele_S_AXI_bready & w_active;
  assign w_pop          = M_AXI_bvalid & M_AXI_bready;
  assign S00_AXI_bvalid = M_AXI_bvalid & w_active & (w_head == SEL_S00);
  assign S01_AXI_bvalid = M_AXI_bvalid & w_active & (w_head == SEL_S01);

  // Head owner is a function of flops only; it moves on a pop or when the first entry lands.
  assign Selected_Slave = w_active ? w_fifo_head : 1'b0;

  assign out_cnt_s00 = r_cnt_s00;
  assign out_cnt_s01 = r_cnt_s01;
  assign err_unexp_b = r_err;

  // Occupancy state: EMPTY until a push, back to EMPTY when the last entry pops with no refill
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_st <= BR_EMPTY;
    end else begin
      case (r_st)
        BR_EMPTY: begin
          if (w_push) r_st <= BR_ACTIVE;
        end
        BR_ACTIVE: begin
          if (w_pop && !w_push && (w_fifo_count == CW'(1))) r_st <= BR_EMPTY;
        end
        default: r_st <= BR_EMPTY;
      endcase
    end
  end

  // Per-interface outstanding counters: push credits the new owner, pop debits the head owner
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt_s00 <= '0;
      r_cnt_s01 <= '0;
    end else begin
      r_cnt_s00 <= r_cnt_s00 + CW'(w_push & (aw_owner == 1'b0))
                             - CW'(w_pop & (w_head == SEL_S00));
      r_cnt_s01 <= r_cnt_s01 + CW'(w_push & (aw_owner == 1'b1))
                             - CW'(w_pop & (w_head == SEL_S01));
    end
  end

  // Sticky flag for a response arriving while nothing is outstanding
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_err <= 1'b0;
    end else if (M_AXI_bvalid && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_bresp_route_ctrl.sv
// tb/tb_axi_bresp_route_ctrl.sv - directed self-checking bench for axi_bresp_route_ctrl
module tb_axi_bresp_route_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          aw_accept;
  logic          aw_owner;
  logic          aw_stall;
  logic          M_AXI_bvalid;
  logic          M_AXI_bready;
  logic          Selected_Slave;
  logic          Sele_S_AXI_bready;
  logic          S00_AXI_bvalid;
  logic          S01_AXI_bvalid;
  logic [CW-1:0] out_cnt_s00;
  logic [CW-1:0] out_cnt_s01;
  logic          err_unexp_b;

  int n_checks = 0;
  int n_pass   = 0;

  axi_bresp_route_ctrl #(.DEPTH(DEPTH)) dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .aw_accept         (aw_accept),
    .aw_owner          (aw_owner),
    .aw_stall          (aw_stall),
    .M_AXI_bvalid      (M_AXI_bvalid),
    .M_AXI_bready      (M_AXI_bready),
    .Selected_Slave    (Selected_Slave),
    .Sele_S_AXI_bready (Sele_S_AXI_bready),
    .S00_AXI_bvalid    (S00_AXI_bvalid),
    .S01_AXI_bvalid    (S01_AXI_bvalid),
    .out_cnt_s00       (out_cnt_s00),
    .out_cnt_s01       (out_cnt_s01),
    .err_unexp_b       (err_unexp_b)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET            = 1'b1;
    aw_accept         = 1'b0;
    aw_owner          = 1'b0;
    M_AXI_bvalid      = 1'b1;
    Sele_S_AXI_bready = 1'b1;

    // Reset held 2 cycles with bvalid high
    tick();
    tick();
    chk("rst_bready", 8'(M_AXI_bready), 8'd0);
    chk("rst_s00v",   8'(S00_AXI_bvalid), 8'd0);
    chk("rst_s01v",   8'(S01_AXI_bvalid), 8'd0);
    chk("rst_stall",  8'(aw_stall), 8'd0);
    chk("rst_sel",    8'(Selected_Slave), 8'd0);
    chk("rst_cnt0",   8'(out_cnt_s00), 8'd0);
    chk("rst_cnt1",   8'(out_cnt_s01), 8'd0);
    chk("rst_err",    8'(err_unexp_b), 8'd0);
    ARESET       = 1'b0;
    M_AXI_bvalid = 1'b0;

    // Ordering: push S01, S00, S01
    aw_accept = 1'b1; aw_owner = 1'b1;
    tick();
    chk("ord_sel_first", 8'(Selected_Slave), 8'd1);
    aw_owner = 1'b0;
    tick();
    aw_owner = 1'b1;
    tick();
    aw_accept = 1'b0;
    chk("ord_cnt0", 8'(out_cnt_s00), 8'd1);
    chk("ord_cnt1", 8'(out_cnt_s01), 8'd2);
    M_AXI_bvalid = 1'b1; Sele_S_AXI_bready = 1'b1;
    #1;
    chk("ord1_s01v",  8'(S01_AXI_bvalid), 8'd1);
    chk("ord1_s00v",  8'(S00_AXI_bvalid), 8'd0);
    chk("ord1_bready", 8'(M_AXI_bready), 8'd1);
    chk("ord1_sel",   8'(Selected_Slave), 8'd1);
    tick();
    chk("ord2_s00v", 8'(S00_AXI_bvalid), 8'd1);
    chk("ord2_s01v", 8'(S01_AXI_bvalid), 8'd0);
    chk("ord2_sel",  8'(Selected_Slave), 8'd0);
    tick();
    chk("ord3_s01v", 8'(S01_AXI_bvalid), 8'd1);
    chk("ord3_sel",  8'(Selected_Slave), 8'd1);
    tick();
    M_AXI_bvalid = 1'b0;
    chk("ord_end_cnt0", 8'(out_cnt_s00), 8'd0);
    chk("ord_end_cnt1", 8'(out_cnt_s01), 8'd0);
    chk("ord_end_sel",  8'(Selected_Slave), 8'd0);
    chk("ord_end_err",  8'(err_unexp_b), 8'd0);

    // Full: 4 x S00, then a 5th accept is ignored
    aw_accept = 1'b1; aw_owner = 1'b0;
    tick();
    chk("fill1_stall", 8'(aw_stall), 8'd0);
    tick();
    tick();
    tick();
    chk("full_stall", 8'(aw_stall), 8'd1);
    chk("full_cnt0",  8'(out_cnt_s00), 8'd4);
    tick();
    chk("full5_cnt0", 8'(out_cnt_s00), 8'd4);
    chk("full5_cnt1", 8'(out_cnt_s01), 8'd0);
    // Pop while full, accept still high: no bypass, stall held this cycle
    M_AXI_bvalid = 1'b1;
    #1;
    chk("fullpop_bready", 8'(M_AXI_bready), 8'd1);
    chk("fullpop_stall",  8'(aw_stall), 8'd1);
    tick();
    aw_accept = 1'b0; M_AXI_bvalid = 1'b0;
    chk("afterpop_stall", 8'(aw_stall), 8'd0);
    chk("afterpop_cnt0",  8'(out_cnt_s00), 8'd3);

    // Backpressure on head S00 for 5 cycles
    M_AXI_bvalid = 1'b1; Sele_S_AXI_bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bready", 8'(M_AXI_bready), 8'd0);
      chk("bp_s00v",   8'(S00_AXI_bvalid), 8'd1);
      chk("bp_s01v",   8'(S01_AXI_bvalid), 8'd0);
      tick();
    end
    chk("bp_cnt0_held", 8'(out_cnt_s00), 8'd3);
    Sele_S_AXI_bready = 1'b1;
    #1;
    chk("bp_release_bready", 8'(M_AXI_bready), 8'd1);
    tick();
    M_AXI_bvalid = 1'b0;
    chk("bp_release_cnt0", 8'(out_cnt_s00), 8'd2);

    // Simultaneous push S01 and pop S00 at count 2
    aw_accept = 1'b1; aw_owner = 1'b1; M_AXI_bvalid = 1'b1;
    tick();
    aw_accept = 1'b0; M_AXI_bvalid = 1'b0;
    chk("sim_cnt0",  8'(out_cnt_s00), 8'd1);
    chk("sim_cnt1",  8'(out_cnt_s01), 8'd1);
    chk("sim_stall", 8'(aw_stall), 8'd0);
    chk("sim_sel",   8'(Selected_Slave), 8'd0);
    M_AXI_bvalid = 1'b1;
    tick();
    chk("sim_drain_sel",  8'(Selected_Slave), 8'd1);
    chk("sim_drain_s01v", 8'(S01_AXI_bvalid), 8'd1);
    tick();
    M_AXI_bvalid = 1'b0;
    chk("sim_end_cnt0", 8'(out_cnt_s00), 8'd0);
    chk("sim_end_cnt1", 8'(out_cnt_s01), 8'd0);
    chk("sim_end_err",  8'(err_unexp_b), 8'd0);

    // Unexpected B while EMPTY
    M_AXI_bvalid = 1'b1;
    #1;
    chk("unexp_bready", 8'(M_AXI_bready), 8'd0);
    chk("unexp_s00v",   8'(S00_AXI_bvalid), 8'd0);
    chk("unexp_s01v",   8'(S01_AXI_bvalid), 8'd0);
    chk("unexp_err_pre", 8'(err_unexp_b), 8'd0);
    tick();
    M_AXI_bvalid = 1'b0;
    chk("unexp_err_set", 8'(err_unexp_b), 8'd1);
    // Normal traffic afterwards leaves the flag set
    aw_accept = 1'b1; aw_owner = 1'b0;
    tick();
    aw_accept = 1'b0; M_AXI_bvalid = 1'b1;
    #1;
    chk("unexp_norm_s00v", 8'(S00_AXI_bvalid), 8'd1);
    tick();
    M_AXI_bvalid = 1'b0;
    chk("unexp_norm_cnt0", 8'(out_cnt_s00), 8'd0);
    chk("unexp_err_sticky", 8'(err_unexp_b), 8'd1);

    // Reset mid-operation: discards outstanding entry and clears the flag
    aw_accept = 1'b1; aw_owner = 1'b1;
    tick();
    aw_accept = 1'b0;
    chk("pre_rst_cnt1", 8'(out_cnt_s01), 8'd1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("rst2_err",  8'(err_unexp_b), 8'd0);
    chk("rst2_cnt1", 8'(out_cnt_s01), 8'd0);
    chk("rst2_sel",  8'(Selected_Slave), 8'd0);
    M_AXI_bvalid = 1'b1;
    #1;
    chk("rst2_bready", 8'(M_AXI_bready), 8'd0);
    chk("rst2_s01v",   8'(S01_AXI_bvalid), 8'd0);
    M_AXI_bvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_bresp_route_ctrl.md
# axi_bresp_route_ctrl

Controller for the 2-to-1 write-response steering path of the AXI interconnect. It records which slave interface (S00 or S01) owns each accepted write address in an in-order ordering FIFO. It drives `Selected_Slave` to the BREADY mux, routes the downstream `bvalid` to the owning interface, and gates the downstream `bready` so a response is never consumed unless its owner accepts it. It also back-pressures the AW arbiter when the outstanding-write limit is reached.

## Interface
- `DEPTH`, default 4: maximum outstanding writes; a power of two, ≥2.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy and per-interface counters (derived, not overridable).
- `ACLK  in  1`: clock; all state updates on the rising edge.
- `ARESET  in  1`: reset, synchronous and active-high.
- `aw_accept  in  1`: a write address was handshaken downstream this cycle (push).
- `aw_owner  in  1`: owner of that address; 0 = S00, 1 = S01.
- `aw_stall  out  1`: ordering FIFO full; the AW arbiter must not grant.
- `M_AXI_bvalid  in  1`: response valid from the downstream slave.
- `M_AXI_bready  out  1`: response ready toward the downstream slave.
- `Selected_Slave  out  1`: select to the BREADY mux; equals the owner of the FIFO head.
- `Sele_S_AXI_bready  in  1`: muxed bready returned from the BREADY mux.
- `S00_AXI_bvalid  out  1`: response valid toward S00.
- `S01_AXI_bvalid  out  1`: response valid toward S01.
- `out_cnt_s00  out  CW`: outstanding writes owned by S00.
- `out_cnt_s01  out  CW`: outstanding writes owned by S01.
- `err_unexp_b  out  1`: sticky flag; `bvalid` was seen with no outstanding write.

## Operation
- State machine `st`, 2 states:
  - EMPTY: count = 0.
  - ACTIVE: count ≥ 1.
  - EMPTY → ACTIVE on push.
  - ACTIVE → EMPTY on a pop with no push while count = 1.
- Push: `aw_accept & ~aw_stall`. Writes `aw_owner` at the write pointer and increments the owner's counter.
- `aw_accept` while `aw_stall` = 1 is a protocol violation. It is ignored: no state change.
- Pop: `bhs = M_AXI_bvalid & M_AXI_bready`. Advances the read pointer and decrements the head owner's counter.
- Combinational outputs:
  - `M_AXI_bready = Sele_S_AXI_bready & (st==ACTIVE)`.
  - `S0x_AXI_bvalid = M_AXI_bvalid & (st==ACTIVE) & (head owner == x)`; the non-owner always sees 0.
- `Selected_Slave` is the head entry's owner when ACTIVE and 0 when EMPTY. It changes only on a pop or on an EMPTY → ACTIVE push.
- `aw_stall = (count == DEPTH)`, combinational from registered count. Stays asserted in a full cycle even if a pop occurs (no same-cycle bypass).
- Simultaneous push and pop (count between 1 and DEPTH−1): count unchanged, both pointers advance.
  - Same owner: that owner's counter is unchanged.
  - Different owners: one counter increments and the other decrements.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is tracked in a separate `CW`-bit count.
- Unexpected B (`M_AXI_bvalid` while EMPTY): `bready` stays 0 and nothing is forwarded. `err_unexp_b` sets next cycle and stays set until `ARESET`.

## Timing
- Reset values (cycle after `ARESET` sampled high):
  - `st` = EMPTY; pointers, count and both counters = 0.
  - `Selected_Slave` = 0, `aw_stall` = 0, `err_unexp_b` = 0.
  - `M_AXI_bready`, `S00_AXI_bvalid`, `S01_AXI_bvalid` = 0.
- Reset mid-operation discards all outstanding entries.
- Push latency is 1 cycle: an entry pushed in cycle N can route a B in cycle N+1 at the earliest. A `bvalid` in cycle N while EMPTY counts as unexpected.
- `bvalid` → `S0x_bvalid` and `Sele_S_AXI_bready` → `M_AXI_bready` have zero cycles of latency (combinational).
- `Selected_Slave` is registered and updates the cycle after a pop, so back-to-back B responses to different owners are sustained at 1 per cycle.
- AXI rule: once `S0x_bvalid` is asserted for the head it stays asserted until the handshake, because the head cannot change without a pop.

## Structure
- Shared package `axi_ic_pkg`:
  - `typedef enum logic {SEL_S00=1'b0, SEL_S01=1'b1} slave_sel_e`.
  - `typedef enum logic {BR_EMPTY, BR_ACTIVE} bresp_st_e`.
- Sub-module `owner_fifo` (width 1, parameter DEPTH) with push, pop, head, full, empty and count. The controller wraps it together with the two counters, routing and error logic.
- The existing BREADY 2:1 mux is instantiated alongside at the parent level, not inside this block.

## Test plan
- Reset: set `ARESET`=1 for 2 cycles with `M_AXI_bvalid`=1 → all outputs 0, counters 0, `err_unexp_b`=0.
- Ordering: push owners S01, S00, S01; hold `M_AXI_bvalid`=1 with both readies 1 → `S01_AXI_bvalid`, `S00_AXI_bvalid`, `S01_AXI_bvalid` in 3 consecutive cycles; `Selected_Slave` = 1, 0, 1; counters end at 0/0.
- Full, DEPTH=4: push 4 × S00 → `aw_stall`=1 and `out_cnt_s00`=4. A 5th `aw_accept` is ignored. One pop → `aw_stall`=0 the next cycle and count=3.
- Backpressure: head owner S00 with `S00_AXI_bready`=0 for 5 cycles → `M_AXI_bready`=0 and `S00_AXI_bvalid` held 1, `S01_AXI_bvalid`=0 throughout. On ready=1 → pop in that cycle.
- Simultaneous events: count=2 (S00 at head); push S01 and pop in the same cycle → count=2, `out_cnt_s00` decrements by 1, `out_cnt_s01` increments by 1.
- Unexpected B: `M_AXI_bvalid`=1 while EMPTY → `M_AXI_bready`=0 and `err_unexp_b`=1 the next cycle. The flag stays set after later normal traffic and clears only on `ARESET`.
